// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] DEF_RDCNT_ADDR = 32'hFFFF_FFF0;
  localparam logic [ADDR_W-1:0] DEF_WRCNT_ADDR = 32'hFFFF_FFF4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;
endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port synchronous RAM with write enable and registered read
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read register only updates on a load, so it holds stable while a response waits
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - word-addressed data-memory responder with wait states
// and memory-mapped load/store access counters
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int                DEPTH      = 64,
  parameter int                LATENCY    = 2,
  parameter logic [ADDR_W-1:0] RDCNT_ADDR = DEF_RDCNT_ADDR,
  parameter logic [ADDR_W-1:0] WRCNT_ADDR = DEF_WRCNT_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t            state, state_nxt;
  logic [CW-1:0]     wait_cnt, wait_cnt_nxt;
  logic              accept, access;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              is_rc, is_wc, acc_err;

  logic [DATA_W-1:0] rd_cnt, wr_cnt, rdata_q, ram_rdata;
  logic              rdata_from_ram, err_q;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    accept       = 1'b0;
    access       = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            access    = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt    = WAIT;
            wait_cnt_nxt = CW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          access    = 1'b1;
          state_nxt = RESP;
        end else begin
          wait_cnt_nxt = wait_cnt - CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, straight from the request
  always_comb begin
    acc_we    = (state == IDLE) ? req_we    : lat_we;
    acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
    acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    is_rc     = (acc_addr == RDCNT_ADDR);
    is_wc     = (acc_addr == WRCNT_ADDR);
    acc_err   = (acc_addr[1:0] != 2'b00) ||
                (!is_rc && !is_wc && (acc_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      lat_we         <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      rd_cnt         <= '0;
      wr_cnt         <= '0;
      rdata_q        <= '0;
      err_q          <= 1'b0;
      rdata_from_ram <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (access) begin
        err_q          <= acc_err;
        rdata_q        <= '0;
        rdata_from_ram <= 1'b0;
        if (!acc_err) begin
          if (!acc_we) begin
            rd_cnt <= rd_cnt + 32'(1);
            if (is_rc)      rdata_q <= rd_cnt;
            else if (is_wc) rdata_q <= wr_cnt;
            else            rdata_from_ram <= 1'b1;
          end else begin
            // A clear of the addressed counter overrides that store's own increment
            if (is_rc) begin
              rd_cnt <= '0;
              wr_cnt <= wr_cnt + 32'(1);
            end else if (is_wc) begin
              wr_cnt <= '0;
            end else begin
              wr_cnt <= wr_cnt + 32'(1);
            end
          end
        end
      end
    end
  end

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (access && !acc_err && !is_rc && !is_wc),
    .we    (acc_we),
    .addr  (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_from_ram ? ram_rdata : rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - self-checking bench for dmem_resp, one instance with two
// wait states and one with none, checked against a transaction-level model
module tb_dmem_resp;

  localparam logic [31:0] RC = 32'hFFFF_FFF0;
  localparam logic [31:0] WC = 32'hFFFF_FFF4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_on = 1'b0;

  // Expected interface state, maintained by the stimulus tasks
  bit          exp_idle  [2];
  bit          exp_valid [2];
  logic [31:0] exp_rdata [2];
  logic        exp_err   [2];

  // Behavioural model: memory image and counters per instance
  logic [31:0] m_mem [2][64];
  logic [31:0] m_rc  [2];
  logic [31:0] m_wc  [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_resp #(.LATENCY(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_resp #(.LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic check(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut%0d) at cycle %0d: got %h, expected %h", name, d, cyc, act, exp);
    end
  endtask

  task automatic model_access(input int d, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rd, output logic err);
    bit is_rc = (addr == RC);
    bit is_wc = (addr == WC);
    int idx   = int'(addr >> 2);
    rd  = 32'h0;
    err = (addr % 4 != 0) || (!is_rc && !is_wc && (addr >> 2) >= 64);
    if (!err) begin
      if (!we) begin
        if (is_rc)      rd = m_rc[d];
        else if (is_wc) rd = m_wc[d];
        else            rd = m_mem[d][idx];
        m_rc[d] = m_rc[d] + 1;
      end else if (is_rc) begin
        m_rc[d] = 0;
        m_wc[d] = m_wc[d] + 1;
      end else if (is_wc) begin
        m_wc[d] = 0;
      end else begin
        m_mem[d][idx] = wdata;
        m_wc[d] = m_wc[d] + 1;
      end
    end
  endtask

  // One full transaction; called and returns at posedge+1
  task automatic txn(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input int hold, output logic [31:0] got_rd, output logic got_err,
                     output int acc_cyc);
    int lat = (d == 0) ? 2 : 0;
    int guard = 0;
    logic [31:0] erd;
    logic        eerr;
    while (!req_ready[d] && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!req_ready[d]) begin
      n_chk++;
      n_fail++;
      $display("FAIL req_ready_timeout (dut%0d): got 0, expected 1", d);
    end
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    req_valid[d] = 1'b0;
    req_wdata[d] = 32'hBAD0_BAD0;
    exp_idle[d]  = 1'b0;
    model_access(d, we, addr, wdata, erd, eerr);
    exp_rdata[d] = erd;
    exp_err[d]   = eerr;
    if (lat > 0) begin
      repeat (lat) @(posedge clk);
      #1;
    end
    exp_valid[d] = 1'b1;
    got_rd  = resp_rdata[d];
    got_err = resp_err[d];
    repeat (hold) begin
      @(posedge clk); #1;
    end
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    exp_valid[d]  = 1'b0;
    exp_idle[d]   = 1'b1;
  endtask

  // Cycle-by-cycle comparison against the expected interface state
  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        if (reset) begin
          check(d, "reset_req_ready", 32'(req_ready[d]), 32'd1);
          check(d, "reset_resp_valid", 32'(resp_valid[d]), 32'd0);
          check(d, "reset_resp_rdata", resp_rdata[d], 32'd0);
          check(d, "reset_resp_err", 32'(resp_err[d]), 32'd0);
        end else begin
          check(d, "req_ready", 32'(req_ready[d]), 32'(exp_idle[d]));
          check(d, "resp_valid", 32'(resp_valid[d]), 32'(exp_valid[d]));
          if (exp_valid[d]) begin
            check(d, "resp_rdata", resp_rdata[d], exp_rdata[d]);
            check(d, "resp_err", 32'(resp_err[d]), 32'(exp_err[d]));
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          c1, c2;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
      resp_ready[d] = 1'b0; exp_idle[d] = 1'b1; exp_valid[d] = 1'b0;
      exp_rdata[d] = '0; exp_err[d] = 1'b0; m_rc[d] = '0; m_wc[d] = '0;
    end
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Store then load with two wait states
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, rd, er, c1);
    check(0, "store_err", 32'(er), 32'd0);
    check(0, "store_rdata", rd, 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, 0, rd, er, c2);
    check(0, "load_rdata", rd, 32'hDEAD_BEEF);
    check(0, "lat2_spacing", 32'(c2 - c1), 32'd4);
    txn(0, 1'b0, RC, 32'h0, 0, rd, er, c1);
    check(0, "load_cnt_after_1", rd, 32'd1);
    txn(0, 1'b0, WC, 32'h0, 0, rd, er, c1);
    check(0, "store_cnt_after_1", rd, 32'd1);

    // Backpressure: response held for five cycles
    txn(0, 1'b0, 32'h10, 32'h0, 5, rd, er, c1);

    // Errors leave RAM and counters alone; index 63 is the last legal word
    txn(0, 1'b1, 32'h0, 32'hA5A5_A5A5, 0, rd, er, c1);
    txn(0, 1'b1, 32'hFC, 32'h0BAD_F00D, 0, rd, er, c1);
    txn(0, 1'b0, 32'h12, 32'h0, 0, rd, er, c1);
    check(0, "misaligned_err", 32'(er), 32'd1);
    check(0, "misaligned_rdata", rd, 32'd0);
    txn(0, 1'b1, 32'h100, 32'h1111_1111, 0, rd, er, c1);
    check(0, "range_err", 32'(er), 32'd1);
    txn(0, 1'b0, 32'h0, 32'h0, 0, rd, er, c1);
    check(0, "mem0_kept", rd, 32'hA5A5_A5A5);
    txn(0, 1'b0, 32'hFC, 32'h0, 0, rd, er, c1);
    check(0, "last_word", rd, 32'h0BAD_F00D);
    check(0, "last_word_err", 32'(er), 32'd0);

    // Counters: clear both, then 3 loads and 2 stores
    txn(0, 1'b1, RC, 32'h0, 0, rd, er, c1);
    txn(0, 1'b1, WC, 32'h0, 0, rd, er, c1);
    for (int i = 0; i < 3; i++) txn(0, 1'b0, 32'h10, 32'h0, 0, rd, er, c1);
    txn(0, 1'b1, 32'h4, 32'h4444_4444, 0, rd, er, c1);
    txn(0, 1'b1, 32'h8, 32'h8888_8888, 0, rd, er, c1);
    txn(0, 1'b0, RC, 32'h0, 0, rd, er, c1);
    check(0, "load_cnt_3", rd, 32'd3);
    txn(0, 1'b0, WC, 32'h0, 0, rd, er, c1);
    check(0, "store_cnt_2", rd, 32'd2);
    txn(0, 1'b1, WC, 32'h0, 0, rd, er, c1);
    txn(0, 1'b0, WC, 32'h0, 0, rd, er, c1);
    check(0, "store_cnt_cleared", rd, 32'd0);
    txn(0, 1'b0, RC, 32'h0, 0, rd, er, c1);
    check(0, "load_cnt_6", rd, 32'd6);

    // Zero wait states: back-to-back accepts two cycles apart
    txn(1, 1'b1, 32'h8, 32'hCAFE_0001, 0, rd, er, c1);
    txn(1, 1'b0, 32'h8, 32'h0, 0, rd, er, c2);
    check(1, "lat0_rdata", rd, 32'hCAFE_0001);
    check(1, "lat0_spacing", 32'(c2 - c1), 32'd2);
    txn(1, 1'b0, 32'h3, 32'h0, 0, rd, er, c1);
    check(1, "lat0_err", 32'(er), 32'd1);

    // Reset during the wait of a store discards it
    txn(0, 1'b1, 32'h20, 32'h1234_5678, 0, rd, er, c1);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h55;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    exp_idle[0]  = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check(0, "midreset_req_ready", 32'(req_ready[0]), 32'd1);
    check(0, "midreset_resp_valid", 32'(resp_valid[0]), 32'd0);
    exp_idle[0] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_rc[d] = '0;
      m_wc[d] = '0;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    txn(0, 1'b0, 32'h20, 32'h0, 0, rd, er, c1);
    check(0, "store_discarded", rd, 32'h1234_5678);
    txn(0, 1'b0, RC, 32'h0, 0, rd, er, c1);
    check(0, "load_cnt_after_reset", rd, 32'd1);
    txn(0, 1'b0, WC, 32'h0, 0, rd, er, c1);
    check(0, "store_cnt_after_reset", rd, 32'd0);

    repeat (2) @(posedge clk);
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-memory responder for the MIPS core's load/store port: word-addressed RAM behind a valid/ready request/response handshake with programmable wait states.
- Also exposes two memory-mapped 32-bit access counters, loads and stores, as a memory-side companion to the core's performance monitor.
- Sits between the datapath's aluout/writedata/readdata signals (via a core-side adapter) and on-chip RAM.

Parameters:
- DEPTH, 64, number of 32-bit words; legal word index 0..DEPTH-1.
- LATENCY, 2, wait-state cycles inserted before the response; 0 is legal.
- RDCNT_ADDR, 32'hFFFF_FFF0, byte address of the load counter.
- WRCNT_ADDR, 32'hFFFF_FFF4, byte address of the store counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- resp_valid  out  1  response present
- resp_ready  in  1  requester takes the response
- resp_rdata  out  32  load data; 0 for stores and errors
- resp_err  out  1  misaligned or out-of-range access

Behaviour:
- Reset (asynchronous, active-high; Already decided): one clock `clk`, reset `reset`.
  - State = IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; both counters = 0.
  - RAM contents are not reset.
  - Reset mid-operation aborts the transaction; a pending store is discarded.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - An accept occurs on edge E when req_valid=1. On E, latch we/addr/wdata.
  - If LATENCY=0, go to RESP and perform the access on E.
  - Otherwise go to WAIT with wait counter = LATENCY-1.
- WAIT:
  - req_ready=0.
  - Each edge: if the counter is 0, go to RESP and perform the access; else decrement.
- Access timing: resp_valid first seen high in the cycle after edge E+LATENCY.
- Performing the access (on the edge entering RESP):
  - err = addr[1:0]!=0, or (addr is not a counter address and addr[31:2] >= DEPTH).
  - err: no RAM write; rdata=0; err=1; counters unchanged.
  - Load, RAM: rdata = mem[addr[31:2]]; load counter +1.
  - Store, RAM: mem[addr[31:2]] = wdata; rdata=0; store counter +1.
  - Load, counter address: rdata = counter value before this access's increment; load counter +1.
  - Store, counter address: clears the addressed counter to 0. The clear wins over this access's own increment, so a store to WRCNT_ADDR leaves the store counter at 0. A store to RDCNT_ADDR clears the load counter, and the store counter +1.
- RESP:
  - req_ready=0.
  - resp_valid=1; rdata/err held stable until the edge where resp_ready=1, then return to IDLE with resp_valid=0.
  - No new accept on that same edge; back-to-back throughput is one transaction per LATENCY+2 cycles.
- Counters: 32-bit, wrap from FFFF_FFFF to 0 without flag.
- Inputs other than resp_ready are ignored outside IDLE.
- req_wdata is don't-care for loads.

Decomposition:
- Package dmem_pkg:
  - state enum (IDLE/WAIT/RESP)
  - default counter addresses
  - width localparams (ADDR_W=32, DATA_W=32)
- One sub-module, dmem_ram: DEPTH x 32 synchronous single-port RAM, write-enable, registered read.
- The FSM, error check and counters live in dmem_resp.

Test Plan:
- Store then load, LATENCY=2: store addr 0x10, data 0xDEADBEEF, accept at edge E → resp_valid high after E+2, err=0; then load 0x10 → rdata=0xDEADBEEF; store counter=1, load counter=1.
- Backpressure: load with resp_ready held 0 for 5 cycles → resp_valid and rdata stable for all 5 cycles, req_ready=0 throughout; IDLE one edge after resp_ready=1.
- Errors: load 0x12 → err=1, rdata=0; store to 0x100 (index 64 = DEPTH) → err=1; mem[0] unchanged; counters unchanged.
- Counters: 3 loads + 2 stores, then load RDCNT_ADDR → rdata=3, then load WRCNT_ADDR → 2; store WRCNT_ADDR → store counter reads back 0.
- LATENCY=0: accept at edge E → resp_valid high in the following cycle; back-to-back accepts 2 cycles apart.
- Mid-operation reset: assert reset during WAIT of a store 0x55 to 0x20 → outputs return to reset values immediately; subsequent load 0x20 ≠ 0x55 (prior value kept).
